pwm_duty_sequencer: RTL and testbench
=====================================

# pwm_duty_sequencer

Duty-cycle sequencer for the PWM-with-interrupt peripheral. Software pushes a queue of duty values through the AXI4-Lite register slave. The block loads one duty value into the PWM counter core at each period boundary, then raises an interrupt when the queue runs low or underruns. It sits between the AXI register bank and the PWM counter core, so the core itself needs no knowledge of buffering.

## Interface
- DATA_WIDTH, 32, width of duty values (matches AXI data bus).
- DEPTH, 8, queue depth; power of two, 2..64.
- LOW_WATER, 2, low-water level (entries) that triggers the refill interrupt; must be less than DEPTH.

- ACLK  in  1  system clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- enable  in  1  run request from control register.
- flush  in  1  one-cycle pulse; empties the queue.
- wr_valid  in  1  duty push request from register write.
- wr_data  in  DATA_WIDTH  duty value to push.
- wr_ready  out  1  push accepted when wr_valid and wr_ready are both high.
- period_end  in  1  one-cycle pulse from the PWM core on its last count of a period.
- load  out  1  one-cycle pulse; the core latches duty_out.
- duty_out  out  DATA_WIDTH  duty value presented to the core.
- level  out  $clog2(DEPTH)+1  current queue occupancy.
- running  out  1  high in RUN state.
- irq  out  1  level-sensitive interrupt, held until acknowledged.
- irq_ack  in  1  one-cycle pulse; clears irq.
- underrun  out  1  sticky; cleared only by irq_ack or reset.

## Operation
- Queue: circular buffer, DEPTH entries.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - level counts 0..DEPTH.
  - Push when full is refused (wr_ready low). Pop when empty never occurs.
  - Simultaneous push and pop: both execute and level is unchanged.
  - No bypass: a push into an empty queue is not poppable in the same cycle.
- flush: resets both pointers and sets level to 0. It takes priority over a same-cycle push and pop; the push is dropped even if wr_ready was high.
- States:
  - IDLE to PRIME when enable = 1.
  - PRIME to RUN when level > 0. On that edge: pop the head, duty_out ← head, load = 1.
  - RUN, period_end with level > 0: pop, duty_out ← head, load = 1.
  - RUN, period_end with level = 0: underrun. Set underrun; load behaviour per Configuration.
  - RUN, enable = 0: go to STOP.
  - STOP: on period_end, duty_out ← 0, load = 1, then go to IDLE. This lets the current period finish cleanly.
  - STOP, enable = 1 again before period_end: return to RUN, no load.
  - PRIME or IDLE with enable = 0: go to IDLE.
- irq_pending is set when either:
  - level falls from LOW_WATER+1 to LOW_WATER while in RUN, or
  - an underrun occurs.
- irq_pending is cleared by irq_ack. If a set and irq_ack land in the same cycle, the set wins. irq = irq_pending.
- flush does not affect irq, underrun or state.

## Timing
- Reset values:
  - state IDLE; level 0; duty_out 0; load 0; running 0; irq 0; underrun 0.
  - wr_ready 0 while ARESET is high, otherwise !full.
- wr_ready is combinational from registered level (!(level == DEPTH)) and ARESET.
- load and duty_out are registered. If period_end is sampled at edge k, load is high during cycle k+1 only.
- Enable latency with a non-empty queue: enable sampled at edge k gives PRIME; load is high after edge k+1 (2-cycle latency).
- irq rises the cycle after its triggering pop or underrun.
- period_end pulses are at least 2 cycles apart, so back-to-back boundaries need no special handling.
- ARESET mid-operation: all state returns to reset values on the next edge. Queue contents are discarded.

## Configuration
- PWM_SEQ_ZERO_ON_UNDERRUN_EN:
  - Defined: on underrun, duty_out ← 0 and load = 1, so the output goes idle-low.
  - Undefined: on underrun, duty_out holds its last value and load stays 0, so the core repeats the previous duty.
- In both builds, underrun and irq are set identically.

## Test plan
- Reset then enable with an empty queue: stays in PRIME and load never pulses. Then push 0x0000_0040: load pulses 2 cycles later with duty_out = 0x40, and running = 1.
- Fill: push 0x10..0x17 (8 values), then one more. The ninth is refused (wr_ready = 0), level = 8. On 8 period_end pulses, duty_out steps 0x10..0x17 in order across the pointer wrap.
- Low water: level 3 in RUN, one period_end takes it to level 2 and irq = 1 the next cycle. irq_ack in the same cycle as a fresh underrun keeps irq = 1; a lone irq_ack clears it.
- Underrun: RUN with level 0 and duty 0x55, then period_end.
  - Macro defined: load = 1 with duty_out = 0.
  - Macro undefined: load = 0 with duty_out = 0x55.
  - Both builds: underrun = 1 and irq = 1.
- Stop and simultaneous events:
  - Drop enable: no load until the next period_end, then load with duty_out = 0 and state IDLE.
  - Push plus period_end pop in the same cycle at level 4: level stays 4.
  - flush plus push in the same cycle: level = 0.
- Reset mid-RUN with level 5 and irq = 1: the next cycle shows level 0, irq 0, underrun 0, duty_out 0, running 0.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// Duty-cycle sequencer: queues duty values from the register slave and hands one to the PWM core per period.
// Optional build macro PWM_SEQ_ZERO_ON_UNDERRUN_EN: on underrun, load a zero duty instead of repeating the last one.
module pwm_duty_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int LOW_WATER  = 2
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    wr_valid,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_ready,
  input  logic                    period_end,
  output logic                    load,
  output logic [DATA_WIDTH-1:0]   duty_out,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    running,
  output logic                    irq,
  input  logic                    irq_ack,
  output logic                    underrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] LOW_LVL   = LW'(LOW_WATER);
  localparam logic [LW-1:0] ABOVE_LOW = LW'(LOW_WATER + 1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [DATA_WIDTH-1:0]   duty_q, duty_d;
  logic                    load_q, load_d;
  logic                    running_q, running_d;
  logic                    irq_q, irq_d;
  logic                    underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  logic                    push_s;
  logic                    pop_s;
  logic                    avail_s;
  logic                    underrun_set_s;
  logic                    low_water_set_s;
  logic [DATA_WIDTH-1:0]   head_s;

  assign wr_ready = ~ARESET & (level_q != FULL_LVL);
  assign push_s   = wr_valid & wr_ready & ~flush;
  // A same-cycle flush hides the queue from the FSM so nothing is popped out of a queue being emptied.
  assign avail_s  = (level_q != '0) & ~flush;
  assign head_s   = mem_q[rd_ptr_q];

  // Sequencer FSM: decides pops, loads and underruns.
  always_comb begin
    state_d        = state_q;
    pop_s          = 1'b0;
    load_d         = 1'b0;
    duty_d         = duty_q;
    underrun_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_PRIME;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (avail_s) begin
          state_d = ST_RUN;
          pop_s   = 1'b1;
          load_d  = 1'b1;
          duty_d  = head_s;
        end else begin
          state_d = ST_PRIME;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_STOP;
        end else if (period_end) begin
          if (avail_s) begin
            pop_s  = 1'b1;
            load_d = 1'b1;
            duty_d = head_s;
          end else if (!flush) begin
            underrun_set_s = 1'b1;
`ifdef PWM_SEQ_ZERO_ON_UNDERRUN_EN
            duty_d = '0;
            load_d = 1'b1;
`else
            duty_d = duty_q;
            load_d = 1'b0;
`endif
          end else begin
            load_d = 1'b0;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STOP: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if (period_end) begin
          state_d = ST_IDLE;
          duty_d  = '0;
          load_d  = 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    running_d = (state_d == ST_RUN);
  end

  // Circular buffer pointers, occupancy and storage.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Interrupt and sticky underrun flags; a set beats a same-cycle acknowledge.
  always_comb begin
    low_water_set_s = (state_q == ST_RUN) && (level_q == ABOVE_LOW) && (level_d == LOW_LVL);
    if (low_water_set_s || underrun_set_s) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
    if (underrun_set_s) begin
      underrun_d = 1'b1;
    end else if (irq_ack) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      duty_q     <= '0;
      load_q     <= 1'b0;
      running_q  <= 1'b0;
      irq_q      <= 1'b0;
      underrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      duty_q     <= duty_d;
      load_q     <= load_d;
      running_q  <= running_d;
      irq_q      <= irq_d;
      underrun_q <= underrun_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign load     = load_q;
  assign duty_out = duty_q;
  assign level    = level_q;
  assign running  = running_q;
  assign irq      = irq_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed, table-driven bench for pwm_duty_sequencer (DEPTH 8, LOW_WATER 2), plus a hand-written reset-mid-run sequence.
module tb_pwm_duty_sequencer;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

`ifdef PWM_SEQ_ZERO_ON_UNDERRUN_EN
  localparam logic UR_LOAD = 1'b1;
`else
  localparam logic UR_LOAD = 1'b0;
`endif

  logic        ACLK;
  logic        ARESET;
  logic        enable;
  logic        flush;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        period_end;
  logic        load;
  logic [31:0] duty_out;
  logic [3:0]  level;
  logic        running;
  logic        irq;
  logic        irq_ack;
  logic        underrun;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        fl;
    logic        wv;
    logic [31:0] wd;
    logic        pe;
    logic        ack;
    logic        load;
    logic [31:0] duty;
    logic [3:0]  level;
    logic        run;
    logic        irq;
    logic        unr;
    logic        wrdy;
  } vec_t;

  vec_t vecs[$];

  pwm_duty_sequencer #(.DATA_WIDTH(32), .DEPTH(8), .LOW_WATER(2)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .enable     (enable),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .period_end (period_end),
    .load       (load),
    .duty_out   (duty_out),
    .level      (level),
    .running    (running),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .underrun   (underrun)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Duty expected after an underrun, given the last loaded duty.
  function automatic logic [31:0] ur_duty(input logic [31:0] last);
    return UR_LOAD ? 32'h0 : last;
  endfunction

  task automatic add(input logic rst, input logic en, input logic fl, input logic wv,
                     input logic [31:0] wd, input logic pe, input logic ack,
                     input logic ld, input logic [31:0] duty, input logic [3:0] lvl,
                     input logic run, input logic iq, input logic unr, input logic wrdy);
    vec_t v;
    v.rst = rst; v.en = en; v.fl = fl; v.wv = wv; v.wd = wd; v.pe = pe; v.ack = ack;
    v.load = ld; v.duty = duty; v.level = lvl; v.run = run; v.irq = iq; v.unr = unr; v.wrdy = wrdy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then let the DUT take one edge; outputs are sampled 1 time unit later.
  task automatic cyc(input logic rst, input logic en, input logic fl, input logic wv,
                     input logic [31:0] wd, input logic pe, input logic ack);
    ARESET = rst; enable = en; flush = fl; wr_valid = wv; wr_data = wd;
    period_end = pe; irq_ack = ack;
    @(posedge ACLK);
    #1;
  endtask

  task automatic apply(input vec_t v, input int k);
    cyc(v.rst, v.en, v.fl, v.wv, v.wd, v.pe, v.ack);
    chk($sformatf("v%0d.load", k),     32'(load),     32'(v.load));
    chk($sformatf("v%0d.duty_out", k), duty_out,      v.duty);
    chk($sformatf("v%0d.level", k),    32'(level),    32'(v.level));
    chk($sformatf("v%0d.running", k),  32'(running),  32'(v.run));
    chk($sformatf("v%0d.irq", k),      32'(irq),      32'(v.irq));
    chk($sformatf("v%0d.underrun", k), 32'(underrun), 32'(v.unr));
    chk($sformatf("v%0d.wr_ready", k), 32'(wr_ready), 32'(v.wrdy));
  endtask

  initial begin
    ARESET = T; enable = F; flush = F; wr_valid = F; wr_data = 32'h0;
    period_end = F; irq_ack = F;

    // Reset, then enable with an empty queue: PRIME waits, period_end ignored.
    add(T,F,F,F,32'h0,F,F, F,32'h0,4'd0,F,F,F,F);
    add(T,F,F,F,32'h0,F,F, F,32'h0,4'd0,F,F,F,F);
    add(F,T,F,F,32'h0,F,F, F,32'h0,4'd0,F,F,F,T);
    add(F,T,F,F,32'h0,F,F, F,32'h0,4'd0,F,F,F,T);
    add(F,T,F,F,32'h0,T,F, F,32'h0,4'd0,F,F,F,T);
    add(F,T,F,T,32'h40,F,F, F,32'h0,4'd1,F,F,F,T);
    add(F,T,F,F,32'h0,F,F, T,32'h40,4'd0,T,F,F,T);
    add(F,T,F,F,32'h0,F,F, F,32'h40,4'd0,T,F,F,T);

    // Fill to DEPTH, refuse the ninth push, drain across the pointer wrap.
    for (int i = 0; i < 8; i++)
      add(F,T,F,T,32'(32'h10 + i),F,F, F,32'h40,4'(i + 1),T,F,F,(i != 7));
    add(F,T,F,T,32'h18,F,F, F,32'h40,4'd8,T,F,F,F);
    for (int i = 0; i < 8; i++) begin
      add(F,T,F,F,32'h0,T,F, T,32'(32'h10 + i),4'(7 - i),T,(i >= 5),F,T);
      add(F,T,F,F,32'h0,F,F, F,32'(32'h10 + i),4'(7 - i),T,(i >= 5),F,T);
    end
    add(F,T,F,F,32'h0,F,T, F,32'h17,4'd0,T,F,F,T);

    // Low water 3->2 raises irq; then underrun with same-cycle ack keeps irq.
    add(F,T,F,T,32'h20,F,F, F,32'h17,4'd1,T,F,F,T);
    add(F,T,F,T,32'h21,F,F, F,32'h17,4'd2,T,F,F,T);
    add(F,T,F,T,32'h22,F,F, F,32'h17,4'd3,T,F,F,T);
    add(F,T,F,F,32'h0,T,F, T,32'h20,4'd2,T,T,F,T);
    add(F,T,F,F,32'h0,F,F, F,32'h20,4'd2,T,T,F,T);
    add(F,T,F,F,32'h0,F,T, F,32'h20,4'd2,T,F,F,T);
    add(F,T,F,F,32'h0,T,F, T,32'h21,4'd1,T,F,F,T);
    add(F,T,F,F,32'h0,F,F, F,32'h21,4'd1,T,F,F,T);
    add(F,T,F,F,32'h0,T,F, T,32'h22,4'd0,T,F,F,T);
    add(F,T,F,F,32'h0,F,F, F,32'h22,4'd0,T,F,F,T);
    add(F,T,F,F,32'h0,T,T, UR_LOAD,ur_duty(32'h22),4'd0,T,T,T,T);
    add(F,T,F,F,32'h0,F,F, F,ur_duty(32'h22),4'd0,T,T,T,T);
    add(F,T,F,F,32'h0,F,T, F,ur_duty(32'h22),4'd0,T,F,F,T);

    // Underrun with last duty 0x55.
    add(F,T,F,T,32'h55,F,F, F,ur_duty(32'h22),4'd1,T,F,F,T);
    add(F,T,F,F,32'h0,T,F, T,32'h55,4'd0,T,F,F,T);
    add(F,T,F,F,32'h0,F,F, F,32'h55,4'd0,T,F,F,T);
    add(F,T,F,F,32'h0,T,F, UR_LOAD,ur_duty(32'h55),4'd0,T,T,T,T);
    add(F,T,F,F,32'h0,F,F, F,ur_duty(32'h55),4'd0,T,T,T,T);
    add(F,T,F,F,32'h0,F,T, F,ur_duty(32'h55),4'd0,T,F,F,T);

    // Push plus pop at level 4 keeps level 4.
    for (int i = 0; i < 4; i++)
      add(F,T,F,T,32'(32'h30 + i),F,F, F,ur_duty(32'h55),4'(i + 1),T,F,F,T);
    add(F,T,F,T,32'h34,T,F, T,32'h30,4'd4,T,F,F,T);
    add(F,T,F,F,32'h0,F,F, F,32'h30,4'd4,T,F,F,T);

    // Stop, resume without load, stop again, final zero load, then IDLE ignores period_end.
    add(F,F,F,F,32'h0,F,F, F,32'h30,4'd4,F,F,F,T);
    add(F,F,F,F,32'h0,F,F, F,32'h30,4'd4,F,F,F,T);
    add(F,T,F,F,32'h0,F,F, F,32'h30,4'd4,T,F,F,T);
    add(F,F,F,F,32'h0,F,F, F,32'h30,4'd4,F,F,F,T);
    add(F,F,F,F,32'h0,T,F, T,32'h0,4'd4,F,F,F,T);
    add(F,F,F,F,32'h0,F,F, F,32'h0,4'd4,F,F,F,T);
    add(F,F,F,F,32'h0,T,F, F,32'h0,4'd4,F,F,F,T);

    // Flush beats a same-cycle push.
    add(F,F,T,T,32'h99,F,F, F,32'h0,4'd0,F,F,F,T);
    add(F,F,F,F,32'h0,F,F, F,32'h0,4'd0,F,F,F,T);

    for (int k = 0; k < vecs.size(); k++)
      apply(vecs[k], k);

    // Reset mid-RUN with level 5 and irq pending.
    cyc(F,T,F,F,32'h0,F,F);
    chk("rm.prime_running", 32'(running), 32'(F));
    cyc(F,T,F,T,32'h60,F,F);
    chk("rm.level1", 32'(level), 32'd1);
    cyc(F,T,F,F,32'h0,F,F);
    chk("rm.load", 32'(load), 32'(T));
    chk("rm.duty", duty_out, 32'h60);
    chk("rm.running", 32'(running), 32'(T));
    cyc(F,T,F,F,32'h0,T,F);
    chk("rm.ur_load", 32'(load), 32'(UR_LOAD));
    chk("rm.ur_duty", duty_out, ur_duty(32'h60));
    chk("rm.ur_flag", 32'(underrun), 32'(T));
    for (int i = 0; i < 5; i++) begin
      cyc(F,T,F,T,32'(32'h61 + i),F,F);
      chk($sformatf("rm.fill%0d", i), 32'(level), 32'(i + 1));
    end
    chk("rm.irq_before", 32'(irq), 32'(T));
    cyc(T,T,F,F,32'h0,F,F);
    chk("rm.level",    32'(level),    32'd0);
    chk("rm.irq",      32'(irq),      32'(F));
    chk("rm.underrun", 32'(underrun), 32'(F));
    chk("rm.duty0",    duty_out,      32'h0);
    chk("rm.running0", 32'(running),  32'(F));
    chk("rm.load0",    32'(load),     32'(F));
    chk("rm.wr_ready_in_reset", 32'(wr_ready), 32'(F));
    cyc(F,F,F,F,32'h0,F,F);
    chk("rm.wr_ready_after", 32'(wr_ready), 32'(T));
    chk("rm.level_after",    32'(level),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
